// File: rtl/prio_select_reg.sv
// Registered NCH-way priority selector with a one-entry valid/ready output stage.
// Optional `PRIO_SELECT_GRANT_CNT_EN adds a saturating 16-bit grant counter port.
module prio_select_reg #(
   parameter int WIDTH     = 1,
   parameter int NCH       = 3,
   parameter bit LAST_WINS = 1'b0,
   localparam int SRCW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SRCW-1:0]      out_src,
   output logic                 out_valid,
   input  logic                 out_ready
`ifdef PRIO_SELECT_GRANT_CNT_EN
  ,output logic [15:0]          grant_cnt
`endif
);

   logic [SRCW-1:0]  sel;
   logic [WIDTH-1:0] win_data;
   logic             any;
   logic             can_load;
   logic             load;

   logic [WIDTH-1:0] data_q, data_d;
   logic [SRCW-1:0]  src_q, src_d;
   logic             vld_q, vld_d;

   // Scan order makes the last valid channel visited the winner.
   function automatic int scan_idx(input int i);
      return (LAST_WINS && NCH > 1) ? i : NCH - 1 - i;
   endfunction

   always_comb begin
      sel      = '0;
      win_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (in_valid[scan_idx(i)]) begin
            sel      = SRCW'(scan_idx(i));
            win_data = in_data[scan_idx(i)*WIDTH +: WIDTH];
         end
      end
   end

   assign any      = |in_valid;
   assign can_load = !vld_q || out_ready;
   assign load     = can_load && any;

   always_comb begin
      in_ready = '0;
      if (load) begin
         in_ready = NCH'(1) << sel;
      end
   end

   always_comb begin
      data_d = data_q;
      src_d  = src_q;
      vld_d  = vld_q;
      if (load) begin
         data_d = win_data;
         src_d  = sel;
         vld_d  = 1'b1;
      end else if (vld_q && out_ready) begin
         vld_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         src_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         src_q  <= src_d;
         vld_q  <= vld_d;
      end
   end

   assign out_data  = data_q;
   assign out_src   = src_q;
   assign out_valid = vld_q;

`ifdef PRIO_SELECT_GRANT_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load && cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_prio_select_reg.sv
// Directed bench for prio_select_reg: first-wins and last-wins instances
// share stimulus; expected values are hand-computed constants.
module tb_prio_select_reg;

   localparam int WIDTH = 4;
   localparam int NCH   = 3;
   localparam int SRCW  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_valid;
   logic                 out_ready;

   logic [NCH-1:0]   f_ready, l_ready;
   logic [WIDTH-1:0] f_data, l_data;
   logic [SRCW-1:0]  f_src, l_src;
   logic             f_valid, l_valid;
`ifdef PRIO_SELECT_GRANT_CNT_EN
   logic [15:0]      f_cnt, l_cnt;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   prio_select_reg #(.WIDTH(WIDTH), .NCH(NCH), .LAST_WINS(1'b0)) u_first (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(f_ready),
      .out_data(f_data), .out_src(f_src), .out_valid(f_valid),
      .out_ready(out_ready)
`ifdef PRIO_SELECT_GRANT_CNT_EN
     ,.grant_cnt(f_cnt)
`endif
   );

   prio_select_reg #(.WIDTH(WIDTH), .NCH(NCH), .LAST_WINS(1'b1)) u_last (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(l_ready),
      .out_data(l_data), .out_src(l_src), .out_valid(l_valid),
      .out_ready(out_ready)
`ifdef PRIO_SELECT_GRANT_CNT_EN
     ,.grant_cnt(l_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 3'b111;
      in_data   = {4'hC, 4'hB, 4'hA};
      out_ready = 1'b0;
      repeat (2) step();

      chk("rst_valid", 32'(f_valid), 32'd0);
      chk("rst_data", 32'(f_data), 32'd0);
      chk("rst_src", 32'(f_src), 32'd0);
      chk("rst_valid_lw", 32'(l_valid), 32'd0);

      rst_n = 1'b1;
      step();
      chk("first_valid", 32'(f_valid), 32'd1);
      chk("first_data", 32'(f_data), 32'hA);
      chk("first_data_lw", 32'(l_data), 32'hC);
      chk("first_src_lw", 32'(l_src), 32'd2);

      // Selection with 3'b110
      out_ready = 1'b1;
      in_valid  = 3'b110;
      #1;
      chk("sel_ready", 32'(f_ready), 32'b010);
      chk("sel_ready_lw", 32'(l_ready), 32'b100);
      step();
      chk("sel_data", 32'(f_data), 32'hB);
      chk("sel_src", 32'(f_src), 32'd1);
      chk("sel_data_lw", 32'(l_data), 32'hC);
      chk("sel_src_lw", 32'(l_src), 32'd2);

      // Stall: inputs change, outputs frozen
      out_ready = 1'b0;
      in_valid  = 3'b111;
      for (int i = 0; i < 3; i++) begin
         in_data = {4'(i + 1), 4'(i + 4), 4'(i + 7)};
         #1;
         chk("stall_ready", 32'(f_ready), 32'd0);
         step();
         chk("stall_data", 32'(f_data), 32'hB);
         chk("stall_src", 32'(f_src), 32'd1);
         chk("stall_valid", 32'(f_valid), 32'd1);
      end

      // Pop and load on the same edge
      out_ready = 1'b1;
      in_valid  = 3'b001;
      in_data   = {4'h0, 4'h0, 4'h5};
      #1;
      chk("popload_ready", 32'(f_ready), 32'b001);
      step();
      chk("popload_valid", 32'(f_valid), 32'd1);
      chk("popload_data", 32'(f_data), 32'h5);
      chk("popload_src", 32'(f_src), 32'd0);

      // Back-to-back throughput
      for (int i = 0; i < 4; i++) begin
         in_valid = 3'b010;
         in_data  = {4'h0, 4'(i + 8), 4'h0};
         step();
         chk("b2b_data", 32'(f_data), 32'(i + 8));
         chk("b2b_src", 32'(f_src), 32'd1);
      end

      // Drain
      in_valid = 3'b000;
      #1;
      chk("drain_ready", 32'(f_ready), 32'd0);
      step();
      chk("drain_valid", 32'(f_valid), 32'd0);
      chk("drain_data_hold", 32'(f_data), 32'hB);
      chk("drain_src_hold", 32'(f_src), 32'd1);

      // Async reset between edges
      in_valid = 3'b100;
      in_data  = {4'h7, 4'h0, 4'h0};
      step();
      chk("pre_arst_valid", 32'(f_valid), 32'd1);
      chk("pre_arst_src", 32'(f_src), 32'd2);
      in_valid  = 3'b000;
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(f_valid), 32'd0);
      chk("arst_data", 32'(f_data), 32'd0);
      chk("arst_src", 32'(f_src), 32'd0);
      chk("arst_valid_lw", 32'(l_valid), 32'd0);
      step();
      rst_n = 1'b1;

`ifdef PRIO_SELECT_GRANT_CNT_EN
      chk("cnt_rst", 32'(f_cnt), 32'd0);
      out_ready = 1'b1;
      in_valid  = 3'b001;
      step();
      chk("cnt_one", 32'(f_cnt), 32'd1);
      repeat (70000) step();
      chk("cnt_sat", 32'(f_cnt), 32'hFFFF);
      step();
      chk("cnt_hold", 32'(f_cnt), 32'hFFFF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("cnt_arst", 32'(f_cnt), 32'd0);
      step();
      rst_n = 1'b1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
